// File: rtl/decode_pkg.sv
// Shared constants and types for the registered instruction decode stage.
package decode_pkg;

    localparam logic [2:0] OPC_B    = 3'b001;
    localparam logic [2:0] OPC_BL   = 3'b010;
    localparam logic [2:0] OPC_LDR  = 3'b011;
    localparam logic [2:0] OPC_STR  = 3'b100;
    localparam logic [2:0] OPC_ALU  = 3'b101;
    localparam logic [2:0] OPC_MOV  = 3'b110;
    localparam logic [2:0] OPC_HALT = 3'b111;

    // Branch conditions carried in instr[10:8]; 111 is reserved.
    localparam logic [2:0] COND_AL = 3'b000;
    localparam logic [2:0] COND_EQ = 3'b001;
    localparam logic [2:0] COND_NE = 3'b010;
    localparam logic [2:0] COND_LT = 3'b011;
    localparam logic [2:0] COND_LE = 3'b100;
    localparam logic [2:0] COND_GT = 3'b101;
    localparam logic [2:0] COND_GE = 3'b110;

    typedef enum logic [1:0] {
        BR_NONE = 2'b00,
        BR_REL  = 2'b01,
        BR_REG  = 2'b10
    } branch_en_e;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_e;

    // Immediates are kept as the raw low byte and sign-extended at the output.
    typedef struct packed {
        logic [2:0] opcode;
        logic [1:0] op;
        logic [2:0] rn;
        logic [2:0] rd;
        logic [2:0] rm;
        logic [1:0] shift;
        logic [1:0] aluop;
        logic [7:0] imm8;
        branch_en_e branch_en;
        logic       illegal;
    } bundle_t;

endpackage

// File: rtl/decode_stage_if.sv
// Handshake and decoded-bundle signals of decode_stage; stat counters exist
// only when DECODE_STATS_EN is defined.
interface decode_stage_if #(
    parameter int DATA_W = 16
`ifdef DECODE_STATS_EN
    , parameter int CNT_W = 16
`endif
);
    logic              in_valid;
    logic              in_ready;
    logic [15:0]       instr;
    logic [2:0]        status;
    logic              flush;
    logic              resume;
    logic              out_valid;
    logic              out_ready;
    logic [2:0]        opcode;
    logic [1:0]        op;
    logic [2:0]        rn;
    logic [2:0]        rd;
    logic [2:0]        rm;
    logic [1:0]        shift;
    logic [1:0]        aluop;
    logic [DATA_W-1:0] sximm5;
    logic [DATA_W-1:0] sximm8;
    logic [1:0]        branch_en;
    logic              illegal;
    logic              halted;
`ifdef DECODE_STATS_EN
    logic [CNT_W-1:0]  stat_instr_cnt;
    logic [CNT_W-1:0]  stat_taken_cnt;
`endif

    modport master (
        output in_valid, instr, status, flush, resume, out_ready,
        input  in_ready, out_valid, opcode, op, rn, rd, rm, shift, aluop,
               sximm5, sximm8, branch_en, illegal, halted
`ifdef DECODE_STATS_EN
        , input stat_instr_cnt, stat_taken_cnt
`endif
    );

    modport slave (
        input  in_valid, instr, status, flush, resume, out_ready,
        output in_ready, out_valid, opcode, op, rn, rd, rm, shift, aluop,
               sximm5, sximm8, branch_en, illegal, halted
`ifdef DECODE_STATS_EN
        , output stat_instr_cnt, stat_taken_cnt
`endif
    );

endinterface

// File: rtl/decode_stage_branch_cond_eval.sv
// Combinational branch resolution and illegal-encoding detection.
module branch_cond_eval
    import decode_pkg::*;
(
    input  logic [2:0] opcode,
    input  logic [1:0] op,
    input  logic [2:0] cond,
    input  logic [2:0] status,
    output branch_en_e branch_en,
    output logic       illegal
);
    logic z, n, v, lt;

    assign z  = status[0];
    assign n  = status[1];
    assign v  = status[2];
    assign lt = n ^ v;

    always_comb begin
        branch_en = BR_NONE;
        illegal   = 1'b0;
        case (opcode)
            OPC_B: begin
                case (cond)
                    COND_AL: branch_en = BR_REL;
                    COND_EQ: branch_en = z ? BR_REL : BR_NONE;
                    COND_NE: branch_en = !z ? BR_REL : BR_NONE;
                    COND_LT: branch_en = lt ? BR_REL : BR_NONE;
                    COND_LE: branch_en = (lt || z) ? BR_REL : BR_NONE;
                    COND_GT: branch_en = (!z && !lt) ? BR_REL : BR_NONE;
                    COND_GE: branch_en = !lt ? BR_REL : BR_NONE;
                    default: illegal = 1'b1;
                endcase
            end
            // BL: op 11 is PC-relative link, 00/10 jump through Rd, 01 reserved.
            OPC_BL: begin
                case (op)
                    2'b11:   branch_en = BR_REL;
                    2'b01:   illegal = 1'b1;
                    default: branch_en = BR_REG;
                endcase
            end
            OPC_LDR, OPC_STR, OPC_ALU, OPC_MOV, OPC_HALT: ;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// Registered instruction decode stage with valid/ready handshake, HALT/resume
// and flush. Optional statistics counters under DECODE_STATS_EN.
module decode_stage
    import decode_pkg::*;
#(
    parameter int DATA_W = 16
`ifdef DECODE_STATS_EN
    , parameter int CNT_W = 16
`endif
) (
    input  logic          clk,
    input  logic          reset_n,
    decode_stage_if.slave bus
);
    localparam logic [0:0] S_RUN  = RUN;
    localparam logic [0:0] S_HALT = HALT;

    logic [0:0] state_q, state_d;
    logic       out_valid_q, out_valid_d;
    bundle_t    bundle_q, bundle_d, dec;
    branch_en_e br_en;
    logic       br_illegal;
    logic       in_ready, accept;

    branch_cond_eval u_branch_cond_eval (
        .opcode    (bus.instr[15:13]),
        .op        (bus.instr[12:11]),
        .cond      (bus.instr[10:8]),
        .status    (bus.status),
        .branch_en (br_en),
        .illegal   (br_illegal)
    );

    // Flush blocks acceptance so the offered instruction is re-presented later.
    assign in_ready = (state_q == S_RUN) && !bus.flush && (!out_valid_q || bus.out_ready);
    assign accept   = bus.in_valid && in_ready;

    always_comb begin
        dec           = '0;
        dec.opcode    = bus.instr[15:13];
        dec.op        = bus.instr[12:11];
        dec.rn        = bus.instr[10:8];
        dec.rd        = bus.instr[7:5];
        dec.rm        = bus.instr[2:0];
        dec.shift     = (dec.opcode == OPC_ALU || dec.opcode == OPC_MOV) ? bus.instr[4:3] : 2'b00;
        dec.aluop     = (dec.opcode == OPC_ALU) ? bus.instr[12:11] : 2'b00;
        dec.imm8      = bus.instr[7:0];
        dec.branch_en = br_en;
        dec.illegal   = br_illegal;
    end

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        bundle_d    = bundle_q;
        if (accept) begin
            bundle_d    = dec;
            out_valid_d = 1'b1;
            if (dec.opcode == OPC_HALT) state_d = S_HALT;
        end else begin
            if (bus.flush || bus.out_ready) out_valid_d = 1'b0;
            if (state_q == S_HALT && bus.resume) state_d = S_RUN;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_RUN;
            out_valid_q <= 1'b0;
            bundle_q    <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            bundle_q    <= bundle_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.opcode    = bundle_q.opcode;
    assign bus.op        = bundle_q.op;
    assign bus.rn        = bundle_q.rn;
    assign bus.rd        = bundle_q.rd;
    assign bus.rm        = bundle_q.rm;
    assign bus.shift     = bundle_q.shift;
    assign bus.aluop     = bundle_q.aluop;
    assign bus.sximm5    = {{(DATA_W-5){bundle_q.imm8[4]}}, bundle_q.imm8[4:0]};
    assign bus.sximm8    = {{(DATA_W-8){bundle_q.imm8[7]}}, bundle_q.imm8};
    assign bus.branch_en = bundle_q.branch_en;
    assign bus.illegal   = bundle_q.illegal;
    assign bus.halted    = (state_q == S_HALT);

`ifdef DECODE_STATS_EN
    logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d, taken_cnt_q, taken_cnt_d;

    always_comb begin
        instr_cnt_d = instr_cnt_q;
        taken_cnt_d = taken_cnt_q;
        if (accept) begin
            instr_cnt_d = instr_cnt_q + 1'b1;
            if (dec.branch_en != BR_NONE) taken_cnt_d = taken_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            instr_cnt_q <= '0;
            taken_cnt_q <= '0;
        end else begin
            instr_cnt_q <= instr_cnt_d;
            taken_cnt_q <= taken_cnt_d;
        end
    end

    assign bus.stat_instr_cnt = instr_cnt_q;
    assign bus.stat_taken_cnt = taken_cnt_q;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: reference model plus directed literals.
module tb_decode_stage;
    localparam int DATA_W = 16;
`ifdef DECODE_STATS_EN
    localparam int CNT_W = 4;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

`ifdef DECODE_STATS_EN
    decode_stage_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();
    decode_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
`else
    decode_stage_if #(.DATA_W(DATA_W)) bus ();
    decode_stage #(.DATA_W(DATA_W)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
`endif

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected bundle {opcode,op,rn,rd,rm,shift,aluop,sximm5,sximm8,branch_en,illegal}.
    function automatic logic [52:0] ref_bundle(input logic [15:0] i, input logic [2:0] st);
        logic [2:0] opc, cond;
        logic [1:0] op, sh, alu, br;
        logic z, n, v, ill, take;
        opc = i[15:13]; op = i[12:11]; cond = i[10:8];
        z = st[0]; n = st[1]; v = st[2];
        sh   = (opc == 3'd5 || opc == 3'd6) ? i[4:3] : 2'b00;
        alu  = (opc == 3'd5) ? op : 2'b00;
        br   = 2'b00; ill = 1'b0; take = 1'b0;
        if (opc == 3'd0) ill = 1'b1;
        else if (opc == 3'd1) begin
            case (cond)
                3'd0: take = 1'b1;
                3'd1: take = z;
                3'd2: take = !z;
                3'd3: take = (n != v);
                3'd4: take = (n != v) || z;
                3'd5: take = !z && (n == v);
                3'd6: take = (n == v);
                default: ill = 1'b1;
            endcase
            br = take ? 2'b01 : 2'b00;
        end else if (opc == 3'd2) begin
            if (op == 2'b01) ill = 1'b1;
            else br = (op == 2'b11) ? 2'b01 : 2'b10;
        end
        return {opc, op, i[10:8], i[7:5], i[2:0], sh, alu,
                {{11{i[4]}}, i[4:0]}, {{8{i[7]}}, i[7:0]}, br, ill};
    endfunction

    logic        m_valid = 1'b0;
    logic        m_halt  = 1'b0;
    logic        m_rdy;
    logic [52:0] m_b     = '0;
    int          m_icnt  = 0;
    int          m_tcnt  = 0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_valid = 1'b0; m_halt = 1'b0; m_b = '0; m_icnt = 0; m_tcnt = 0;
        end else begin
            m_rdy = !m_halt && !bus.flush && (!m_valid || bus.out_ready);
            if (bus.in_valid && m_rdy) begin
                m_b     = ref_bundle(bus.instr, bus.status);
                m_valid = 1'b1;
                m_icnt++;
                if (m_b[2:1] != 2'b00) m_tcnt++;
                if (bus.instr[15:13] == 3'b111) m_halt = 1'b1;
            end else begin
                if (bus.flush || bus.out_ready) m_valid = 1'b0;
                if (bus.resume) m_halt = 1'b0;
            end
        end
    end

    always begin
        @(posedge clk);
        #2;
        chk("out_valid", bus.out_valid, m_valid);
        chk("halted", bus.halted, m_halt);
        chk("in_ready", bus.in_ready, !m_halt && !bus.flush && (!m_valid || bus.out_ready));
        if (m_valid)
            chk("bundle", {bus.opcode, bus.op, bus.rn, bus.rd, bus.rm, bus.shift, bus.aluop,
                           bus.sximm5, bus.sximm8, bus.branch_en, bus.illegal}, m_b);
`ifdef DECODE_STATS_EN
        chk("stat_instr_cnt", bus.stat_instr_cnt, m_icnt % (1 << CNT_W));
        chk("stat_taken_cnt", bus.stat_taken_cnt, m_tcnt % (1 << CNT_W));
`endif
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    // Offer one instruction from a falling edge; returns at the next falling edge.
    task automatic step(input logic [15:0] i, input logic [2:0] st);
        bus.in_valid = 1'b1;
        bus.instr    = i;
        bus.status   = st;
        @(negedge clk);
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.instr = '0; bus.status = '0;
        bus.flush = 1'b0; bus.resume = 1'b0; bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_opcode", bus.opcode, 0);
        chk("rst_sximm8", bus.sximm8, 0);
        chk("rst_branch_en", bus.branch_en, 0);
        chk("rst_illegal", bus.illegal, 0);
        chk("rst_halted", bus.halted, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        reset_n = 1'b1;

        step(16'hA0A3, 3'b000);
        chk("alu_out_valid", bus.out_valid, 1);
        chk("alu_aluop", bus.aluop, 2'b00);
        chk("alu_rd", bus.rd, 5);
        chk("alu_rm", bus.rm, 3);
        chk("alu_shift", bus.shift, 0);
        chk("alu_illegal", bus.illegal, 0);
        chk("alu_sximm8", bus.sximm8, 16'hFFA3);
        chk("alu_sximm5", bus.sximm5, 16'h0003);

        step(16'h2510, 3'b110); chk("gt_taken", bus.branch_en, 2'b01);
        step(16'h2510, 3'b111); chk("gt_z_not_taken", bus.branch_en, 2'b00);
        step(16'h2610, 3'b010); chk("ge_not_taken", bus.branch_en, 2'b00);
        step(16'h2710, 3'b000);
        chk("cond7_illegal", bus.illegal, 1);
        chk("cond7_branch_en", bus.branch_en, 2'b00);
        step(16'h5800, 3'b000); chk("bl_rel", bus.branch_en, 2'b01);
        step(16'h4000, 3'b000); chk("blx_reg", bus.branch_en, 2'b10);
        step(16'h4800, 3'b000); chk("bl_op01_illegal", bus.illegal, 1);
        step(16'h0123, 3'b000); chk("opc0_illegal", bus.illegal, 1);

        // Backpressure: held bundle (rd=1) must not move while the next waits.
        bus.out_ready = 1'b0;
        bus.instr     = 16'hC0E1;
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready", bus.in_ready, 0);
            chk("bp_hold_rd", bus.rd, 1);
            chk("bp_hold_valid", bus.out_valid, 1);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_next_opcode", bus.opcode, 3'b110);
        chk("bp_next_rd", bus.rd, 7);
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("bp_drained", bus.out_valid, 0);

        // Flush kills the held bundle and refuses the offered instruction.
        step(16'hA0A3, 3'b000);
        bus.flush = 1'b1;
        bus.instr = 16'hB8E2;
        @(negedge clk);
        chk("flush_valid", bus.out_valid, 0);
        bus.flush = 1'b0;
        @(negedge clk);
        chk("reoffer_valid", bus.out_valid, 1);
        chk("reoffer_aluop", bus.aluop, 2'b11);
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("reoffer_once", bus.out_valid, 0);

        // HALT then resume.
        step(16'hE000, 3'b000);
        chk("halt_bundle", bus.opcode, 3'b111);
        chk("halt_halted", bus.halted, 1);
        bus.instr = 16'hA0A3;
        repeat (5) begin
            @(negedge clk);
            chk("halt_in_ready", bus.in_ready, 0);
        end
        bus.resume = 1'b1;
        @(negedge clk);
        bus.resume = 1'b0;
        chk("resume_halted", bus.halted, 0);
        chk("resume_in_ready", bus.in_ready, 1);
        @(negedge clk);
        chk("resume_accept", bus.opcode, 3'b101);
        bus.in_valid = 1'b0;
        @(negedge clk);

        // Async reset while halted with a bundle held.
        step(16'hE000, 3'b000);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        #3 reset_n = 1'b0;
        #1;
        chk("rst_mid_valid", bus.out_valid, 0);
        chk("rst_mid_halted", bus.halted, 0);
        chk("rst_mid_opcode", bus.opcode, 0);
        bus.out_ready = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_in_ready", bus.in_ready, 1);

`ifdef DECODE_STATS_EN
        chk("stat_clear", bus.stat_instr_cnt, 0);
        for (int k = 0; k < 17; k++)
            step((k % 6 == 1) ? 16'h2010 : 16'hA0A3, 3'b000);
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("stat_instr_wrap", bus.stat_instr_cnt, 1);
        chk("stat_taken", bus.stat_taken_cnt, 3);
`endif

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
